// File: rtl/fetch_queue.sv
// ----------------------------------------------------------------------------
// fetch_queue
//
// Purpose:
//   Fetch stage between the instruction ROM and Tomasulo issue. It drives a
//   word-addressed pc into the ROM and takes back instr/isdone in the same
//   cycle. Fetched {pc, instr} pairs are buffered in an in-order FIFO that
//   issue drains with a valid/ready handshake. A branch redirect (flush)
//   empties the queue and restarts fetching at flush_pc. Fetching stops when
//   the ROM reports the halt opcode.
//
// Parameters:
//   DEPTH     FIFO entries (power of two, >= 2)
//   RESET_PC  word address fetched first after reset
//
// Ports:
//   clk          in   1   clock, rising edge
//   rst_n        in   1   asynchronous active-low reset
//   pc           out  32  fetch address to ROM (word index)
//   instr        in   32  ROM data for pc, valid in the same cycle
//   isdone       in   1   ROM flag: instr is the halt opcode
//   flush_valid  in   1   redirect request from branch resolution
//   flush_pc     in   32  redirect target
//   issue_valid  out  1   head entry available
//   issue_instr  out  32  head instruction (don't-care when !issue_valid)
//   issue_pc     out  32  pc of head instruction (don't-care when !issue_valid)
//   issue_ready  in   1   issue consumes head when issue_valid && issue_ready
//   halted       out  1   halt opcode seen; fetching stopped (FSM state)
//   drained      out  1   halted and FIFO empty
//
// Optional feature (macro FETCH_QUEUE_PERF_EN):
//   perf_fetched out 32  number of pushes, wraps at 2^32
//   perf_stall   out 32  cycles running with a full queue and no pop
//   Neither counter is cleared by flush.
//
// Handshake: an entry leaves the queue on a rising edge where issue_valid
// and issue_ready are both high; issue_valid never depends on issue_ready.
// ----------------------------------------------------------------------------
module fetch_queue #(
    parameter int unsigned DEPTH    = 8,
    parameter logic [31:0] RESET_PC = 32'd0
) (
    input  logic        clk,
    input  logic        rst_n,
    output logic [31:0] pc,
    input  logic [31:0] instr,
    input  logic        isdone,
    input  logic        flush_valid,
    input  logic [31:0] flush_pc,
    output logic        issue_valid,
    output logic [31:0] issue_instr,
    output logic [31:0] issue_pc,
    input  logic        issue_ready,
    output logic        halted,
`ifdef FETCH_QUEUE_PERF_EN
    output logic        drained,
    output logic [31:0] perf_fetched,
    output logic [31:0] perf_stall
`else
    output logic        drained
`endif
);

    localparam int unsigned PW = $clog2(DEPTH);
    localparam int unsigned CW = PW + 1;
    localparam logic [CW-1:0] FULL_COUNT = CW'(DEPTH);

    typedef enum logic {
        ST_RUN  = 1'b0,
        ST_HALT = 1'b1
    } state_t;

    state_t          state_q, state_d;
    logic [31:0]     pc_q, pc_d;
    logic [PW-1:0]   rd_ptr_q, rd_ptr_d;
    logic [PW-1:0]   wr_ptr_q, wr_ptr_d;
    logic [CW-1:0]   count_q, count_d;

    // Storage carries no reset: entries are only visible through count_q.
    logic [31:0]     mem_pc_q    [DEPTH];
    logic [31:0]     mem_instr_q [DEPTH];

    logic            pop;
    logic            fetch_ok;
    logic            push;
    logic            full;

    assign full        = (count_q == FULL_COUNT);
    assign issue_valid = (count_q != '0);
    assign pop         = issue_valid && issue_ready;
    // A pop in the same cycle frees a slot, so a full queue can still accept.
    assign fetch_ok    = (state_q == ST_RUN) && !flush_valid && (!full || pop);
    // The halt word itself is never queued.
    assign push        = fetch_ok && !isdone;

    // ------------------------------------------------------------------
    // Next-state logic
    // ------------------------------------------------------------------
    always_comb begin
        state_d  = state_q;
        pc_d     = pc_q;
        rd_ptr_d = rd_ptr_q;
        wr_ptr_d = wr_ptr_q;
        count_d  = count_q;

        if (flush_valid) begin
            // Redirect wins over everything: same-cycle pop is ignored and
            // the ROM word for the old pc is dropped.
            state_d  = ST_RUN;
            pc_d     = flush_pc;
            rd_ptr_d = '0;
            wr_ptr_d = '0;
            count_d  = '0;
        end else begin
            if (pop) begin
                rd_ptr_d = rd_ptr_q + PW'(1);
            end
            if (fetch_ok) begin
                if (isdone) begin
                    // pc stays parked on the halt address.
                    state_d = ST_HALT;
                end else begin
                    pc_d     = pc_q + 32'd1;
                    wr_ptr_d = wr_ptr_q + PW'(1);
                end
            end
            case ({push, pop})
                2'b10:   count_d = count_q + CW'(1);
                2'b01:   count_d = count_q - CW'(1);
                default: count_d = count_q;
            endcase
        end
    end

    // ------------------------------------------------------------------
    // State registers
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= ST_RUN;
            pc_q     <= RESET_PC;
            rd_ptr_q <= '0;
            wr_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            state_q  <= state_d;
            pc_q     <= pc_d;
            rd_ptr_q <= rd_ptr_d;
            wr_ptr_q <= wr_ptr_d;
            count_q  <= count_d;
        end
    end

    always_ff @(posedge clk) begin
        if (push) begin
            mem_pc_q[wr_ptr_q]    <= pc_q;
            mem_instr_q[wr_ptr_q] <= instr;
        end
    end

    // ------------------------------------------------------------------
    // Outputs: all registered, no path from instr/isdone.
    // ------------------------------------------------------------------
    assign pc          = pc_q;
    assign issue_instr = mem_instr_q[rd_ptr_q];
    assign issue_pc    = mem_pc_q[rd_ptr_q];
    assign halted      = (state_q == ST_HALT);
    assign drained     = halted && !issue_valid;

`ifdef FETCH_QUEUE_PERF_EN
    logic [31:0] perf_fetched_q;
    logic [31:0] perf_stall_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            perf_fetched_q <= '0;
            perf_stall_q   <= '0;
        end else begin
            if (push) begin
                perf_fetched_q <= perf_fetched_q + 32'd1;
            end
            if (!halted && full && !pop) begin
                perf_stall_q <= perf_stall_q + 32'd1;
            end
        end
    end

    assign perf_fetched = perf_fetched_q;
    assign perf_stall   = perf_stall_q;
`endif

endmodule

// File: tb/tb_fetch_queue.sv
module tb_fetch_queue;

    localparam int          DEPTH    = 8;
    localparam logic [31:0] RESET_PC = 32'd0;

    logic        clk;
    logic        rst_n;
    logic [31:0] pc;
    logic [31:0] instr;
    logic        isdone;
    logic        flush_valid;
    logic [31:0] flush_pc;
    logic        issue_valid;
    logic [31:0] issue_instr;
    logic [31:0] issue_pc;
    logic        issue_ready;
    logic        halted;
    logic        drained;
`ifdef FETCH_QUEUE_PERF_EN
    logic [31:0] perf_fetched;
    logic [31:0] perf_stall;
`endif

    int n_cmp;
    int n_err;

    // ---------------- clock ----------------
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // ---------------- ROM model ----------------
    logic [31:0] halt_addr;
    bit          halt_rand;

    function automatic logic rom_is_halt(input logic [31:0] a);
        return (a == halt_addr) || (halt_rand && ((a % 29) == 28));
    endfunction

    function automatic logic [31:0] rom_word(input logic [31:0] a);
        if (rom_is_halt(a)) return {6'h3f, a[25:0]};
        return {6'h04, a[25:0] ^ 26'h1555555};
    endfunction

    assign instr  = rom_word(pc);
    assign isdone = (instr[31:26] == 6'h3f);

    // ---------------- DUT ----------------
    fetch_queue #(.DEPTH(DEPTH), .RESET_PC(RESET_PC)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .pc          (pc),
        .instr       (instr),
        .isdone      (isdone),
        .flush_valid (flush_valid),
        .flush_pc    (flush_pc),
        .issue_valid (issue_valid),
        .issue_instr (issue_instr),
        .issue_pc    (issue_pc),
        .issue_ready (issue_ready),
        .halted      (halted),
`ifdef FETCH_QUEUE_PERF_EN
        .drained     (drained),
        .perf_fetched(perf_fetched),
        .perf_stall  (perf_stall)
`else
        .drained     (drained)
`endif
    );

    // ---------------- reference model ----------------
    // The queue is an ordinary SV queue of {pc, instr}; the model walks the
    // fetch rules cycle by cycle from the architectural view.
    logic [63:0] m_q[$];
    logic [31:0] m_pc;
    bit          m_halted;
    logic [31:0] m_fetched;
    logic [31:0] m_stall;

    function automatic void m_reset();
        m_q.delete();
        m_pc      = RESET_PC;
        m_halted  = 1'b0;
        m_fetched = '0;
        m_stall   = '0;
    endfunction

    function automatic void m_step(input bit rdy, input bit fl, input logic [31:0] fpc);
        int          n;
        bit          take;
        logic [31:0] w;
        n    = m_q.size();
        take = (n > 0) && rdy;
        if (!m_halted && n == DEPTH && !take) m_stall = m_stall + 1;
        if (fl) begin
            m_q.delete();
            m_halted = 1'b0;
            m_pc     = fpc;
        end else begin
            if (take) void'(m_q.pop_front());
            if (!m_halted && (n < DEPTH || take)) begin
                w = rom_word(m_pc);
                if (w[31:26] == 6'h3f) begin
                    m_halted = 1'b1;
                end else begin
                    m_q.push_back({m_pc, w});
                    m_pc      = m_pc + 1;
                    m_fetched = m_fetched + 1;
                end
            end
        end
    endfunction

    // ---------------- scoreboard helpers ----------------
    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic check_model(input string tag);
        chk({tag, ".issue_valid"}, 32'(issue_valid), 32'(m_q.size() != 0));
        if (m_q.size() != 0) begin
            chk({tag, ".issue_pc"},    issue_pc,    m_q[0][63:32]);
            chk({tag, ".issue_instr"}, issue_instr, m_q[0][31:0]);
        end
        chk({tag, ".pc"},      pc,              m_pc);
        chk({tag, ".halted"},  32'(halted),     32'(m_halted));
        chk({tag, ".drained"}, 32'(drained),    32'(m_halted && m_q.size() == 0));
`ifdef FETCH_QUEUE_PERF_EN
        chk({tag, ".perf_fetched"}, perf_fetched, m_fetched);
        chk({tag, ".perf_stall"},   perf_stall,   m_stall);
`endif
    endtask

    // ---------------- driver tasks ----------------
    // Inputs change #1 after a rising edge; outputs are sampled #1 after the next.
    task automatic drive_edge(input bit rdy, input bit fl, input logic [31:0] fpc);
        issue_ready = rdy;
        flush_valid = fl;
        flush_pc    = fpc;
        m_step(rdy, fl, fpc);
        @(posedge clk);
        #1;
    endtask

    task automatic cycle(input string tag, input bit rdy, input bit fl, input logic [31:0] fpc);
        drive_edge(rdy, fl, fpc);
        check_model(tag);
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        issue_ready = 1'b0;
        flush_valid = 1'b0;
        flush_pc    = '0;
        #1;
        m_reset();
        @(posedge clk);
        #1;
        rst_n = 1'b1;
    endtask

    // ---------------- directed vector table ----------------
    typedef struct {
        bit          rdy;
        bit          fl;
        logic [31:0] fpc;
        bit          exp_valid;
        logic [31:0] exp_hpc;
        logic [31:0] exp_pc;
        bit          exp_halted;
        bit          exp_drained;
    } vec_t;

    vec_t vecs[14];

    initial begin
        n_cmp       = 0;
        n_err       = 0;
        rst_n       = 1'b0;
        issue_ready = 1'b0;
        flush_valid = 1'b0;
        flush_pc    = '0;
        halt_addr   = 32'd3;
        halt_rand   = 1'b0;

        // Reset state
        repeat (2) @(posedge clk);
        #1;
        chk("reset.issue_valid", 32'(issue_valid), 32'd0);
        chk("reset.pc",          pc,               RESET_PC);
        chk("reset.halted",      32'(halted),      32'd0);
        chk("reset.drained",     32'(drained),     32'd0);
        m_reset();
        rst_n = 1'b1;

        // ROM 0..3 = A,B,C,HALT streaming; then flush to 0x20, fill 5,
        // flush to 0x40 with a same-cycle ready, then resume.
        vecs[0]  = '{1, 0, 32'h0,  1, 32'h0,  32'h1,  0, 0};
        vecs[1]  = '{1, 0, 32'h0,  1, 32'h1,  32'h2,  0, 0};
        vecs[2]  = '{1, 0, 32'h0,  1, 32'h2,  32'h3,  0, 0};
        vecs[3]  = '{1, 0, 32'h0,  0, 32'h0,  32'h3,  1, 1};
        vecs[4]  = '{1, 0, 32'h0,  0, 32'h0,  32'h3,  1, 1};
        vecs[5]  = '{0, 1, 32'h20, 0, 32'h0,  32'h20, 0, 0};
        vecs[6]  = '{0, 0, 32'h0,  1, 32'h20, 32'h21, 0, 0};
        vecs[7]  = '{0, 0, 32'h0,  1, 32'h20, 32'h22, 0, 0};
        vecs[8]  = '{0, 0, 32'h0,  1, 32'h20, 32'h23, 0, 0};
        vecs[9]  = '{0, 0, 32'h0,  1, 32'h20, 32'h24, 0, 0};
        vecs[10] = '{0, 0, 32'h0,  1, 32'h20, 32'h25, 0, 0};
        vecs[11] = '{1, 1, 32'h40, 0, 32'h0,  32'h40, 0, 0};
        vecs[12] = '{1, 0, 32'h0,  1, 32'h40, 32'h41, 0, 0};
        vecs[13] = '{1, 0, 32'h0,  1, 32'h41, 32'h42, 0, 0};

        for (int i = 0; i < 14; i++) begin
            drive_edge(vecs[i].rdy, vecs[i].fl, vecs[i].fpc);
            chk($sformatf("vec%0d.issue_valid", i), 32'(issue_valid), 32'(vecs[i].exp_valid));
            if (vecs[i].exp_valid) begin
                chk($sformatf("vec%0d.issue_pc", i),    issue_pc,    vecs[i].exp_hpc);
                chk($sformatf("vec%0d.issue_instr", i), issue_instr, rom_word(vecs[i].exp_hpc));
            end
            chk($sformatf("vec%0d.pc", i),      pc,            vecs[i].exp_pc);
            chk($sformatf("vec%0d.halted", i),  32'(halted),   32'(vecs[i].exp_halted));
            chk($sformatf("vec%0d.drained", i), 32'(drained),  32'(vecs[i].exp_drained));
        end

        // Fill to full with ready low, 4 stall cycles, then stream with no bubble.
        halt_addr = 32'hffff_ffff;
        do_reset();
        for (int i = 0; i < 12; i++) cycle("full", 1'b0, 1'b0, '0);
        chk("full.pc_held",   pc,               32'd8);
        chk("full.head_pc",   issue_pc,         32'd0);
        chk("full.valid",     32'(issue_valid), 32'd1);
`ifdef FETCH_QUEUE_PERF_EN
        chk("full.perf_stall",   perf_stall,   32'd4);
        chk("full.perf_fetched", perf_fetched, 32'd8);
`endif
        for (int i = 0; i < 6; i++) cycle("stream", 1'b1, 1'b0, '0);
        chk("stream.pc",      pc,       32'd14);
        chk("stream.head_pc", issue_pc, 32'd6);

        // Halted with 2 entries, then redirect to 0x10.
        halt_addr = 32'd2;
        do_reset();
        for (int i = 0; i < 4; i++) cycle("halt2", 1'b0, 1'b0, '0);
        chk("halt2.halted",  32'(halted), 32'd1);
        chk("halt2.pc",      pc,          32'd2);
        chk("halt2.head_pc", issue_pc,    32'd0);
        cycle("hflush", 1'b0, 1'b1, 32'h10);
        chk("hflush.halted", 32'(halted),      32'd0);
        chk("hflush.valid",  32'(issue_valid), 32'd0);
        chk("hflush.pc",     pc,               32'h10);
        cycle("hresume", 1'b1, 1'b0, '0);
        chk("hresume.head_pc", issue_pc, 32'h10);
        chk("hresume.pc",      pc,       32'h11);

        // Asynchronous reset between edges.
        halt_addr = 32'hffff_ffff;
        do_reset();
        for (int i = 0; i < 5; i++) cycle("pre_rst", i[0], 1'b0, '0);
        #2;
        rst_n = 1'b0;
        #1;
        chk("arst.issue_valid", 32'(issue_valid), 32'd0);
        chk("arst.pc",          pc,               RESET_PC);
        chk("arst.halted",      32'(halted),      32'd0);
        m_reset();
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        cycle("refill", 1'b1, 1'b0, '0);
        chk("refill.head_pc", issue_pc, RESET_PC);

        // Randomized traffic with occasional halts and redirects.
        halt_rand = 1'b1;
        do_reset();
        for (int i = 0; i < 600; i++) begin
            bit          rdy;
            bit          fl;
            logic [31:0] fpc;
            rdy = ($urandom_range(0, 9) < 6);
            fl  = ($urandom_range(0, 24) == 0);
            fpc = 32'($urandom_range(0, 300));
            cycle("rand", rdy, fl, fpc);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
